// File: rtl/gsim_mat_mem_resp.sv
// gsim_mat_mem_resp
//   Matrix-memory responder for the GSIM solver. Row-read requests (10-bit
//   row address) are queued in a small FIFO. Each row is fetched from a
//   single-port 64-bit SRAM as four consecutive beats. The beats are
//   assembled into a 256-bit row, which is returned with a one-cycle valid
//   pulse. Fixed 6-cycle latency from acceptance (empty queue) to valid.
//   Sustained throughput is one row per 4 cycles, in acceptance order.
//
// Optional feature: define GSIM_MEM_RANGE_CHK_EN to enable the row range
//   check. Rows >= 17*i_matrix_num are then returned as zero with
//   o_range_err, and the SRAM is not read for them.
//
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_rreq, i_addr      read request / row address (taken on i_rreq && o_rrdy)
//   i_matrix_num        loaded problem count (range check only)
//   o_rrdy              request queue can accept this cycle (registered)
//   o_dout, o_dout_vld  assembled row and its one-cycle valid pulse
//   o_range_err         out-of-range flag, pulses with o_dout_vld
//   o_sram_ren          SRAM read enable
//   o_sram_addr         SRAM word address {row, beat}
//   i_sram_q            SRAM read data, valid one cycle after o_sram_ren
module gsim_mat_mem_resp #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_rreq,
  input  logic [9:0]   i_addr,
  input  logic [4:0]   i_matrix_num,
  output logic         o_rrdy,
  output logic [255:0] o_dout,
  output logic         o_dout_vld,
  output logic         o_range_err,
  output logic         o_sram_ren,
  output logic [11:0]  o_sram_addr,
  input  logic [63:0]  i_sram_q
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  // ---------------- request FIFO ----------------
  logic [9:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          rrdy_reg;
  logic          push, pop;
  logic [9:0]    head_row;

  // A full queue never accepts, even if a pop happens in the same cycle,
  // because o_rrdy is a register computed from the previous cycle.
  assign push     = i_rreq && rrdy_reg;
  assign head_row = fifo_mem[rd_ptr_reg];
  assign o_rrdy   = rrdy_reg;

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CW'(1);
    else if (pop && !push)
      count_next = count_reg - CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= i_addr;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      rrdy_reg   <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
      rrdy_reg  <= (count_next < CW'(FIFO_DEPTH));
    end
  end

  // ---------------- fetch FSM ----------------
  state_t     state_reg, state_next;
  logic [1:0] beat_reg, beat_next;
  logic       issue;
  logic       row_err;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= S_IDLE;
      beat_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    pop        = 1'b0;
    issue      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        beat_next = 2'd0;
        if (count_reg != '0)
          state_next = S_ISSUE;
      end
      S_ISSUE: begin
        issue     = 1'b1;
        beat_next = beat_reg + 2'd1;
        if (beat_reg == 2'd3) begin
          pop       = 1'b1;
          beat_next = 2'd0;
          // Continue without a bubble only if another row was already queued
          // before this cycle; a row pushed right now goes through IDLE so the
          // latency from acceptance stays fixed.
          if (count_reg > CW'(1))
            state_next = S_ISSUE;
          else
            state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef GSIM_MEM_RANGE_CHK_EN
  logic [9:0] row_limit;
  assign row_limit = {5'd0, i_matrix_num} * 10'd17;
  assign row_err   = issue && (head_row >= row_limit);
`else
  logic unused_matrix_num;
  assign unused_matrix_num = ^i_matrix_num;
  assign row_err           = 1'b0;
`endif

  // Out-of-range rows keep their four issue slots but do not touch the SRAM.
  assign o_sram_ren  = issue && !row_err;
  assign o_sram_addr = issue ? {head_row, beat_reg} : 12'd0;

  // ---------------- tag pipeline (follows each issue by one cycle) ----------------
  logic       tag_vld_reg, tag_last_reg, tag_err_reg;
  logic [1:0] tag_beat_reg;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tag_vld_reg  <= 1'b0;
      tag_last_reg <= 1'b0;
      tag_err_reg  <= 1'b0;
      tag_beat_reg <= 2'd0;
    end else begin
      tag_vld_reg  <= issue;
      tag_last_reg <= issue && (beat_reg == 2'd3);
      tag_err_reg  <= row_err;
      tag_beat_reg <= beat_reg;
    end
  end

  // ---------------- assembly and output ----------------
  logic [63:0]  beat_data;
  logic [2:0]   lane_we;
  logic [191:0] asm_reg;
  logic [255:0] dout_reg;
  logic         dout_vld_reg, range_err_reg;

  assign beat_data = tag_err_reg ? 64'd0 : i_sram_q;

  // Beats 0..2 park in the assembly register; beat 3 goes straight into the
  // output register together with them, so the next row's beat 0 can land in
  // the assembly register on the very next cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign lane_we[gi] = tag_vld_reg && (tag_beat_reg == 2'(gi));
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      asm_reg       <= '0;
      dout_reg      <= '0;
      dout_vld_reg  <= 1'b0;
      range_err_reg <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (lane_we[k])
          asm_reg[64*k +: 64] <= beat_data;
      end
      dout_vld_reg  <= tag_vld_reg && tag_last_reg;
      range_err_reg <= tag_vld_reg && tag_last_reg && tag_err_reg;
      if (tag_vld_reg && tag_last_reg)
        dout_reg <= {beat_data, asm_reg};
    end
  end

  assign o_dout      = dout_reg;
  assign o_dout_vld  = dout_vld_reg;
  assign o_range_err = range_err_reg;

endmodule

// File: tb/tb_gsim_mat_mem_resp.sv
// Testbench for gsim_mat_mem_resp: directed scenarios followed by randomized
// requests, checked against a schedule-level reference model.
module tb_gsim_mat_mem_resp;

  localparam int DEPTH = 2;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_rreq = 1'b0;
  logic [9:0]   i_addr = '0;
  logic [4:0]   i_matrix_num = '0;
  logic         o_rrdy;
  logic [255:0] o_dout;
  logic         o_dout_vld;
  logic         o_range_err;
  logic         o_sram_ren;
  logic [11:0]  o_sram_addr;
  logic [63:0]  i_sram_q = '0;

  gsim_mat_mem_resp #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rreq       (i_rreq),
    .i_addr       (i_addr),
    .i_matrix_num (i_matrix_num),
    .o_rrdy       (o_rrdy),
    .o_dout       (o_dout),
    .o_dout_vld   (o_dout_vld),
    .o_range_err  (o_range_err),
    .o_sram_ren   (o_sram_ren),
    .o_sram_addr  (o_sram_addr),
    .i_sram_q     (i_sram_q)
  );

  always #5 i_clk = ~i_clk;

  // SRAM model: one-cycle read latency; garbage when not enabled.
  logic [63:0] sram [4096];
  always @(posedge i_clk) begin
    if (o_sram_ren)
      i_sram_q <= sram[o_sram_addr];
    else
      i_sram_q <= {$urandom, $urandom};
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: each accepted row gets an issue start cycle.
  // start = max(accept_edge + 1, previous_start + 4); valid at start + 5;
  // the row leaves the queue at the edge start + 4.
  typedef struct packed {
    int row;
    int start;
  } req_t;

  req_t pend[$];
  int   script[$];
  int   last_start = -100;
  int   cyc = 0;
  bit   rand_mode = 0;
  logic prev_req = 0;
  logic prev_rrdy = 0;

  function automatic bit in_range(input int row);
`ifdef GSIM_MEM_RANGE_CHK_EN
    return row < 17 * int'(i_matrix_num);
`else
    return (row >= 0);
`endif
  endfunction

  function automatic logic [255:0] exp_row(input int row);
    logic [255:0] r;
    if (!in_range(row))
      return '0;
    r = {sram[row*4+3], sram[row*4+2], sram[row*4+1], sram[row*4]};
    return r;
  endfunction

  task automatic step();
    int         cnt;
    logic       exp_ren, exp_vld, exp_rrdy;
    logic [11:0] exp_addr;
    req_t       r;
    @(posedge i_clk);
    #1;
    cyc++;
    if (prev_req && prev_rrdy) begin
      r.row   = int'(i_addr);
      r.start = (cyc + 1 > last_start + 4) ? cyc + 1 : last_start + 4;
      last_start = r.start;
      pend.push_back(r);
      $display("cycle %0d: accepted row %0d", cyc, r.row);
    end
    cnt = 0;
    exp_ren = 1'b0;
    exp_addr = '0;
    foreach (pend[i]) begin
      if (pend[i].start + 4 > cyc)
        cnt++;
      if (cyc >= pend[i].start && cyc <= pend[i].start + 3) begin
        exp_ren  = in_range(pend[i].row);
        exp_addr = 12'(pend[i].row * 4 + (cyc - pend[i].start));
      end
    end
    exp_rrdy = (cnt < DEPTH);
    check("rrdy", 256'(o_rrdy), 256'(exp_rrdy));
    check("sram_ren", 256'(o_sram_ren), 256'(exp_ren));
    if (exp_ren)
      check("sram_addr", 256'(o_sram_addr), 256'(exp_addr));
    exp_vld = (pend.size() > 0) && (pend[0].start + 5 == cyc);
    check("dout_vld", 256'(o_dout_vld), 256'(exp_vld));
    if (exp_vld) begin
      r = pend.pop_front();
      check("dout", o_dout, exp_row(r.row));
      check("range_err", 256'(o_range_err), 256'(!in_range(r.row)));
      $display("cycle %0d: returned row %0d dout=%0h range_err=%0b", cyc, r.row, o_dout, o_range_err);
    end
    // Requester holds an unaccepted request.
    if (!(i_rreq && !exp_rrdy)) begin
      if (script.size() > 0) begin
        i_rreq = 1'b1;
        i_addr = 10'(script.pop_front());
      end else if (rand_mode) begin
        i_rreq = ($urandom % 3) != 0;
        i_addr = 10'($urandom_range(0, 560));
      end else begin
        i_rreq = 1'b0;
      end
    end
    prev_req  = i_rreq;
    prev_rrdy = exp_rrdy;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_rreq  = 1'b0;
    #1;
    check("rst_rrdy", 256'(o_rrdy), 256'(0));
    check("rst_dout", o_dout, 256'(0));
    check("rst_dout_vld", 256'(o_dout_vld), 256'(0));
    check("rst_range_err", 256'(o_range_err), 256'(0));
    check("rst_sram_ren", 256'(o_sram_ren), 256'(0));
    check("rst_sram_addr", 256'(o_sram_addr), 256'(0));
    repeat (2) begin
      @(posedge i_clk);
      cyc++;
    end
    #1;
    i_reset = 1'b0;
    pend.delete();
    script.delete();
    last_start = -100;
    prev_req   = 1'b0;
    prev_rrdy  = 1'b0;
    $display("cycle %0d: reset released", cyc);
  endtask

  initial begin
    for (int w = 0; w < 4096; w++)
      sram[w] = 64'(w);
    i_matrix_num = 5'd2;
    #3;
    do_reset();

    // Single read of row 5.
    script.push_back(5);
    repeat (10) step();

    // Back-to-back rows 0..3 (queue fills, pop/full interaction).
    for (int k = 0; k < 4; k++)
      script.push_back(k);
    repeat (24) step();

    // Range boundary with i_matrix_num = 2: row 34 out, row 33 in.
    script.push_back(34);
    script.push_back(33);
    repeat (16) step();

    // Reset at beat 2 of row 7 with row 8 queued; nothing must come back.
    script.push_back(7);
    script.push_back(8);
    repeat (5) step();
    do_reset();
    repeat (8) step();
    script.push_back(9);
    repeat (10) step();

    // Randomized traffic with random data and problem counts.
    for (int w = 0; w < 4096; w++)
      sram[w] = {$urandom, $urandom};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      i_matrix_num = 5'($urandom_range(0, 31));
      rand_mode = 1;
      repeat (150) step();
      rand_mode = 0;
      repeat (24) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
